// File: rtl/raiden_game_ctrl.sv
// Game-flow controller for the Raiden dot-matrix game.
// Sequences IDLE -> PLAY <-> RESPAWN -> OVER, paces the game with a one-cycle
// tick, rate-limits fire into tick-aligned grants, hides the enemy for a few
// ticks after each hit, and keeps the round timer and the hit count.
module raiden_game_ctrl #(
    parameter int unsigned MOVE_DIV    = 4194304, // clock cycles per game tick (>=2)
    parameter int unsigned ROUND_TICKS = 600,     // ticks per round (1..1023)
    parameter int unsigned HIT_HOLD    = 5,       // ticks the enemy stays hidden after a hit (>=1)
    parameter int unsigned FIRE_GAP    = 2        // minimum ticks between fire grants (>=1)
) (
    input  logic       clk,
    input  logic       rst,           // synchronous, active-low
    input  logic       start,
    input  logic       fire_req,
    input  logic       hit,
    output logic       tick,
    output logic       fire_en,
    output logic       enemy_visible,
    output logic       clear_field,
    output logic       game_over,
    output logic [1:0] state,
    output logic [9:0] time_left,
    output logic [7:0] hits
);

    localparam int unsigned DIV_W  = $clog2(MOVE_DIV);
    localparam int unsigned RESP_W = $clog2(HIT_HOLD + 1);
    localparam int unsigned COOL_W = $clog2(FIRE_GAP + 1);

    localparam logic [DIV_W-1:0]  DIV_MAX    = DIV_W'(MOVE_DIV - 1);
    localparam logic [RESP_W-1:0] RESP_LOAD  = RESP_W'(HIT_HOLD);
    localparam logic [COOL_W-1:0] COOL_LOAD  = COOL_W'(FIRE_GAP - 1);
    localparam logic [9:0]        TIME_LOAD  = 10'(ROUND_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PLAY    = 2'b01,
        ST_RESPAWN = 2'b10,
        ST_OVER    = 2'b11
    } state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  div_q;
    logic [RESP_W-1:0] resp_q;
    logic [COOL_W-1:0] cool_q;
    logic              start_q;
    logic              tick_q;
    logic              fire_en_q;
    logic              enemy_visible_q;
    logic              clear_field_q;
    logic              game_over_q;
    logic [9:0]        time_left_q;
    logic [7:0]        hits_q;

    logic running;
    logic tick_ev;
    logic start_edge;
    logic expire;
    logic fire_ok;

    // Per-cycle events derived from the current registered state.
    always_comb begin
        running    = (state_q == ST_PLAY) || (state_q == ST_RESPAWN);
        tick_ev    = running && (div_q == DIV_MAX);
        start_edge = start && !start_q;
        // Timer expiry is the tick that takes time_left from 1 to 0.
        expire     = tick_ev && (time_left_q == 10'd1);
        fire_ok    = tick_ev && fire_req && (cool_q == '0);
    end

    // Phase sequencer, tick divider, fire cooldown and all registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled only on the clock edge, so it sits inside the
        // clocked branch rather than in the sensitivity list.
        if (!rst) begin
            state_q         <= ST_IDLE;
            div_q           <= '0;
            resp_q          <= '0;
            cool_q          <= '0;
            start_q         <= 1'b0;
            tick_q          <= 1'b0;
            fire_en_q       <= 1'b0;
            enemy_visible_q <= 1'b0;
            clear_field_q   <= 1'b0;
            game_over_q     <= 1'b0;
            time_left_q     <= '0;
            hits_q          <= '0;
        end else begin
            start_q       <= start;
            tick_q        <= tick_ev;
            fire_en_q     <= fire_ok;
            clear_field_q <= 1'b0;

            case (state_q)
                ST_IDLE, ST_OVER: begin
                    div_q <= '0;
                    if (start_edge) begin
                        state_q         <= ST_PLAY;
                        clear_field_q   <= 1'b1;
                        time_left_q     <= TIME_LOAD;
                        hits_q          <= '0;
                        cool_q          <= '0;
                        resp_q          <= '0;
                        enemy_visible_q <= 1'b1;
                        game_over_q     <= 1'b0;
                    end
                end

                ST_PLAY, ST_RESPAWN: begin
                    div_q <= tick_ev ? '0 : div_q + DIV_W'(1);

                    if (tick_ev) begin
                        time_left_q <= time_left_q - 10'd1;
                        if (fire_ok) begin
                            cool_q <= COOL_LOAD;
                        end else if (cool_q != '0) begin
                            cool_q <= cool_q - COOL_W'(1);
                        end
                    end

                    // Expiry outranks both a fresh hit and respawn completion.
                    if (expire) begin
                        state_q         <= ST_OVER;
                        game_over_q     <= 1'b1;
                        enemy_visible_q <= 1'b0;
                        resp_q          <= '0;
                    end else if (state_q == ST_PLAY) begin
                        if (hit) begin
                            state_q         <= ST_RESPAWN;
                            enemy_visible_q <= 1'b0;
                            resp_q          <= RESP_LOAD;
                            if (hits_q != 8'hFF) begin
                                hits_q <= hits_q + 8'd1;
                            end
                        end
                    end else if (tick_ev) begin
                        // Hits while the enemy is hidden are ignored.
                        resp_q <= resp_q - RESP_W'(1);
                        if (resp_q == RESP_W'(1)) begin
                            state_q         <= ST_PLAY;
                            enemy_visible_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tick          = tick_q;
    assign fire_en       = fire_en_q;
    assign enemy_visible = enemy_visible_q;
    assign clear_field   = clear_field_q;
    assign game_over     = game_over_q;
    assign state         = state_q;
    assign time_left     = time_left_q;
    assign hits          = hits_q;

endmodule

// File: tb/tb_raiden_game_ctrl.sv
// Self-checking bench for raiden_game_ctrl with a short divider and round.
// A vector table covers reset, round start, tick pacing and fire rate limiting;
// hand-written sequences cover round expiry, respawn, hit/expiry priority and
// mid-game reset.
module tb_raiden_game_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       fire_req;
    logic       hit;
    logic       tick;
    logic       fire_en;
    logic       enemy_visible;
    logic       clear_field;
    logic       game_over;
    logic [1:0] state;
    logic [9:0] time_left;
    logic [7:0] hits;

    int n_checks = 0;
    int n_fail   = 0;

    raiden_game_ctrl #(
        .MOVE_DIV   (4),
        .ROUND_TICKS(10),
        .HIT_HOLD   (3),
        .FIRE_GAP   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .fire_req     (fire_req),
        .hit          (hit),
        .tick         (tick),
        .fire_en      (fire_en),
        .enemy_visible(enemy_visible),
        .clear_field  (clear_field),
        .game_over    (game_over),
        .state        (state),
        .time_left    (time_left),
        .hits         (hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs applied before the edge, outputs after it.
    typedef struct {
        logic        rst;
        logic        start;
        logic        fire;
        logic        hit;
        logic [24:0] exp; // {tick, fire_en, vis, clr, over, state, time_left, hits}
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic h,
                                input logic tk, input logic fe, input logic vi, input logic cl,
                                input logic ov, input logic [1:0] st, input int tl, input int hc);
        vec_t v;
        v.rst   = r;
        v.start = s;
        v.fire  = f;
        v.hit   = h;
        v.exp   = {tk, fe, vi, cl, ov, st, 10'(tl), 8'(hc)};
        return v;
    endfunction

    function automatic logic [24:0] observed();
        return {tick, fire_en, enemy_visible, clear_field, game_over, state, time_left, hits};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nt;
        int reached;
        logic saw_over;

        rst      = 1'b0;
        start    = 1'b0;
        fire_req = 1'b0;
        hit      = 1'b0;

        //                   rst st fr ht  tk fe vi cl ov state  time hits
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,  0, 0);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,  0, 0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 10, 0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10, 0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10, 0);
        vecs[5]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 10, 0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01,  9, 0);
        vecs[7]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  9, 0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  9, 0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  9, 0);
        vecs[10] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  8, 0);
        vecs[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  8, 0);
        vecs[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  8, 0);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  8, 0);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01,  7, 0);
        vecs[15] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  7, 0);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  7, 0);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  7, 0);
        vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  6, 0);
        vecs[19] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  6, 0);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  6, 0);
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  6, 0);
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01,  5, 0);

        // Reset, start held high, fire held then pulsed between ticks.
        for (int i = 0; i < 23; i++) begin
            rst      = vecs[i].rst;
            start    = vecs[i].start;
            fire_req = vecs[i].fire;
            hit      = vecs[i].hit;
            step();
            check($sformatf("vec[%0d]", i), 32'(observed()), 32'(vecs[i].exp));
        end

        // Finish the round with no hits: five more ticks, then silence in OVER.
        start    = 1'b0;
        fire_req = 1'b0;
        nt       = 0;
        saw_over = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick) begin
                nt++;
                if (nt == 5) saw_over = (state == 2'b11);
            end
        end
        check("round_ticks", 32'(nt), 32'd5);
        check("over_on_last_tick", 32'(saw_over), 32'd1);
        check("over_state", 32'(state), 32'd3);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_time", 32'(time_left), 32'd0);
        check("over_vis", 32'(enemy_visible), 32'd0);

        // Restart from OVER.
        start = 1'b1;
        step();
        check("restart_state", 32'(state), 32'd1);
        check("restart_clear", 32'(clear_field), 32'd1);
        check("restart_time", 32'(time_left), 32'd10);
        check("restart_over", 32'(game_over), 32'd0);
        check("restart_vis", 32'(enemy_visible), 32'd1);
        step();
        check("restart_clear_drop", 32'(clear_field), 32'd0);

        // Hit in PLAY, second hit ignored during RESPAWN, back after three ticks.
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit_state", 32'(state), 32'd2);
        check("hit_vis", 32'(enemy_visible), 32'd0);
        check("hit_count", 32'(hits), 32'd1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("hit2_state", 32'(state), 32'd2);
        check("hit2_count", 32'(hits), 32'd1);
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick) nt++;
            if (state == 2'b01) break;
        end
        check("respawn_ticks", 32'(nt), 32'd3);
        check("respawn_state", 32'(state), 32'd1);
        check("respawn_vis", 32'(enemy_visible), 32'd1);
        check("respawn_time", 32'(time_left), 32'd7);
        check("respawn_hits", 32'(hits), 32'd1);

        // Hit on the same edge as the expiring tick: expiry wins.
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (time_left == 10'd1) begin
                reached = 1;
                break;
            end
        end
        check("wait_time1_a", 32'(reached), 32'd1);
        step();
        step();
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("expire_hit_state", 32'(state), 32'd3);
        check("expire_hit_hits", 32'(hits), 32'd1);
        check("expire_hit_over", 32'(game_over), 32'd1);

        // RESPAWN entered with one tick left: expiry beats respawn completion.
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        check("restart2_hits", 32'(hits), 32'd0);
        reached = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (time_left == 10'd1) begin
                reached = 1;
                break;
            end
        end
        check("wait_time1_b", 32'(reached), 32'd1);
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("late_hit_state", 32'(state), 32'd2);
        check("late_hit_time", 32'(time_left), 32'd1);
        reached = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick) begin
                reached = 1;
                break;
            end
        end
        check("late_tick_seen", 32'(reached), 32'd1);
        check("late_expire_state", 32'(state), 32'd3);
        check("late_expire_hits", 32'(hits), 32'd1);

        // Reset for one edge in RESPAWN, then a start edge is needed to resume.
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        hit   = 1'b1;
        step();
        hit = 1'b0;
        check("pre_reset_state", 32'(state), 32'd2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_reset_outputs", 32'(observed()), 32'd0);
        nt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick) nt++;
        end
        check("post_reset_ticks", 32'(nt), 32'd0);
        check("post_reset_state", 32'(state), 32'd0);
        start = 1'b1;
        step();
        check("resume_state", 32'(state), 32'd1);
        check("resume_clear", 32'(clear_field), 32'd1);
        check("resume_time", 32'(time_left), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/raiden_game_ctrl.md
# raiden_game_ctrl

Game-flow controller for the Raiden dot-matrix game. It sequences the play session through idle, play, enemy-respawn and game-over phases, and generates the single-cycle game tick that paces bullet movement. It rate-limits player fire into one-cycle grants, gates enemy visibility after a hit, and counts the round timer and hit total. It sits between the keypad/collision logic and the bullet/frame datapath, which consume `tick`, `fire_en`, `enemy_visible` and `clear_field`.

## Interface
- `MOVE_DIV`, 4194304: clock cycles per game tick (≥2).
- `ROUND_TICKS`, 600: ticks per round (1..1023).
- `HIT_HOLD`, 5: ticks the enemy stays hidden after a hit (≥1).
- `FIRE_GAP`, 2: minimum ticks between fire grants (≥1).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: start request, level, already synchronous to `clk`.
- `fire_req` in 1: fire button held, level.
- `hit` in 1: one-cycle pulse from collision logic, enemy struck.
- `tick` out 1: one-cycle game-step pulse.
- `fire_en` out 1: one-cycle fire grant, coincident with `tick`.
- `enemy_visible` out 1: enemy drawn and collidable.
- `clear_field` out 1: one-cycle pulse, datapath clears bullets and score.
- `game_over` out 1: high in OVER.
- `state` out 2: IDLE=00, PLAY=01, RESPAWN=10, OVER=11.
- `time_left` out 10: remaining round ticks.
- `hits` out 8: hits this round, saturating at 255.

## Operation
- All outputs registered. Reset values: `state`=IDLE; `tick`, `fire_en`, `enemy_visible`, `clear_field`, `game_over` = 0; `time_left`=0; `hits`=0; divider, cooldown, respawn counters and the `start` history flop = 0.
- The start edge is `start`=1 while the registered previous `start`=0.
- IDLE: divider held at 0, no ticks. Start edge → PLAY, `clear_field`=1 for one cycle, `time_left`=ROUND_TICKS, `hits`=0, cooldown=0, `enemy_visible`=1.
- PLAY: divider counts 0..MOVE_DIV-1 and wraps. The wrap produces a tick. On each tick, `time_left` decrements.
  - If `time_left` becomes 0 → OVER.
  - Else if `hit` → RESPAWN, `enemy_visible`=0, respawn count=HIT_HOLD, `hits`+1 (saturating).
- RESPAWN: divider continues. Each tick decrements `time_left` and the respawn count. Respawn count reaching 0 → PLAY with `enemy_visible`=1. `hit` is ignored.
- OVER: divider held at 0, `game_over`=1, `enemy_visible`=0, `time_left`=0. Start edge → PLAY with the same entry actions as from IDLE, including `clear_field`.
- Fire (PLAY and RESPAWN only):
  - On a tick with `fire_req`=1 and cooldown=0: `fire_en`=1 that cycle, cooldown loaded FIRE_GAP-1.
  - Otherwise a tick decrements a nonzero cooldown.
  - `fire_req` between ticks is not latched.
- Priorities within a cycle:
  - Timer expiry beats hit and respawn completion.
  - A hit on a tick cycle also decrements `time_left`.
  - A start edge in PLAY or RESPAWN is ignored.
- Reset mid-operation: all state and outputs return to reset values on the next edge, regardless of phase.

## Timing
- Start edge sampled at edge N: `state`=PLAY and `clear_field`=1 during cycle N..N+1.
- First `tick` is high for the cycle following edge N+MOVE_DIV, then every MOVE_DIV cycles. `tick` is always exactly 1 cycle wide.
- `time_left` updates on the same edge that raises `tick`. The transition to OVER occurs on that same edge, so no tick ever occurs in OVER.
- `hit` sampled at edge M in PLAY: `enemy_visible`=0 and `state`=RESPAWN after edge M. Return to PLAY occurs on the edge raising the HIT_HOLD-th subsequent tick.
- Fire latency: the grant coincides with the tick that sampled `fire_req`. With FIRE_GAP=1, a grant may occur every tick.

## Test plan
(Bench parameters: MOVE_DIV=4, ROUND_TICKS=10, HIT_HOLD=3, FIRE_GAP=2.)
- Reset, then `start` held high 20 cycles → exactly one `clear_field` pulse; ticks every 4 cycles; `time_left` 10→9→8…
- Run a full round with no hits → after the 10th tick, `state`=11, `game_over`=1, `time_left`=0, no further ticks. A new start edge → PLAY with `time_left`=10 and `clear_field` pulse.
- `hit` pulse in PLAY, plus a second `hit` during RESPAWN → `enemy_visible` low for exactly 3 ticks; `hits`=1; return to `state`=01.
- `fire_req` held high continuously → `fire_en` on ticks 1, 3, 5…, each coincident with `tick`. `fire_req` pulsed only between ticks → no grant.
- `hit` on the same cycle as the tick taking `time_left` to 0 → OVER, `hits` unchanged; during RESPAWN with `time_left`=1 → OVER at the next tick.
- `rst` low mid-RESPAWN for one edge → all outputs return to reset values; `start` edge is required to resume play.
